// File: rtl/addr_ser.sv
`default_nettype none
// ============================================================================
// Module      : addr_ser
// Description : Master-side serial address driver. Captures a parallel
//               address, shifts the device field out LSB first, waits for
//               the decoder's acknowledge, then shifts the in-slave memory
//               field out LSB first. Reports done, ack timeout or grant loss.
// Revision    : 1.0 - initial release
// ============================================================================
module addr_ser #(
    parameter int ADDR_WIDTH        = 16,
    parameter int DEVICE_ADDR_WIDTH = 4,
    parameter int ACK_TIMEOUT       = 15
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic                  grant,
    input  logic                  ack,
    output logic                  addr_valid,
    output logic                  addr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic                  abort
);

    localparam int c_MEM_WIDTH = ADDR_WIDTH - DEVICE_ADDR_WIDTH;
    localparam int c_CNT_W     = $clog2(ADDR_WIDTH) + 1;

    localparam logic [c_CNT_W-1:0] c_DEV_BITS  = c_CNT_W'(DEVICE_ADDR_WIDTH);
    localparam logic [c_CNT_W-1:0] c_MEM_BITS  = c_CNT_W'(c_MEM_WIDTH);
    localparam logic [7:0]         c_ACK_LIMIT = 8'(ACK_TIMEOUT);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_DEV      = 3'd1;
    localparam logic [2:0] c_ST_WAIT_ACK = 3'd2;
    localparam logic [2:0] c_ST_MEM      = 3'd3;
    localparam logic [2:0] c_ST_FIN      = 3'd4;

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_shift;     // remaining address bits, next bit in [0]
    logic [c_CNT_W-1:0]    r_bit_cnt;   // bits already presented in current field
    logic [7:0]            r_to_cnt;    // cycles spent waiting for ack
    logic                  r_addr_valid;
    logic                  r_addr_data;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_timeout;
    logic                  r_abort;

    logic                  w_in_xfer;
    logic [7:0]            w_to_next;

    // Grant is only policed while the bus is actually being driven or held.
    assign w_in_xfer = (r_state == c_ST_DEV) || (r_state == c_ST_WAIT_ACK) ||
                       (r_state == c_ST_MEM);
    assign w_to_next = r_to_cnt + 8'd1;

    // Transfer sequencer: every output is produced directly from a register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= c_ST_IDLE;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_to_cnt     <= '0;
            r_addr_valid <= 1'b0;
            r_addr_data  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
            r_abort      <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_abort   <= 1'b0;
            if (w_in_xfer && !grant) begin
                // Losing the bus outranks ack and timeout.
                r_state      <= c_ST_IDLE;
                r_addr_valid <= 1'b0;
                r_addr_data  <= 1'b0;
                r_busy       <= 1'b0;
                r_abort      <= 1'b1;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (start && grant) begin
                            // First device bit goes out on the very next cycle.
                            r_state      <= c_ST_DEV;
                            r_busy       <= 1'b1;
                            r_addr_valid <= 1'b1;
                            r_addr_data  <= addr_in[0];
                            r_shift      <= addr_in >> 1;
                            r_bit_cnt    <= c_CNT_W'(1);
                        end
                    end
                    c_ST_DEV: begin
                        if (r_bit_cnt == c_DEV_BITS) begin
                            r_state      <= c_ST_WAIT_ACK;
                            r_addr_valid <= 1'b0;
                            r_addr_data  <= 1'b0;
                            r_to_cnt     <= '0;
                        end else begin
                            r_addr_data <= r_shift[0];
                            r_shift     <= r_shift >> 1;
                            r_bit_cnt   <= r_bit_cnt + c_CNT_W'(1);
                        end
                    end
                    c_ST_WAIT_ACK: begin
                        if (ack) begin
                            // Ack wins even on the cycle the limit is reached.
                            r_state      <= c_ST_MEM;
                            r_addr_valid <= 1'b1;
                            r_addr_data  <= r_shift[0];
                            r_shift      <= r_shift >> 1;
                            r_bit_cnt    <= c_CNT_W'(1);
                        end else if (w_to_next == c_ACK_LIMIT) begin
                            r_state   <= c_ST_IDLE;
                            r_busy    <= 1'b0;
                            r_timeout <= 1'b1;
                            r_to_cnt  <= '0;
                        end else begin
                            r_to_cnt <= w_to_next;
                        end
                    end
                    c_ST_MEM: begin
                        if (r_bit_cnt == c_MEM_BITS) begin
                            r_state      <= c_ST_FIN;
                            r_addr_valid <= 1'b0;
                            r_addr_data  <= 1'b0;
                            r_busy       <= 1'b0;
                            r_done       <= 1'b1;
                        end else begin
                            r_addr_data <= r_shift[0];
                            r_shift     <= r_shift >> 1;
                            r_bit_cnt   <= r_bit_cnt + c_CNT_W'(1);
                        end
                    end
                    c_ST_FIN: begin
                        // done is visible for this single cycle; start is not sampled here.
                        r_state <= c_ST_IDLE;
                    end
                    default: begin
                        r_state      <= c_ST_IDLE;
                        r_addr_valid <= 1'b0;
                        r_addr_data  <= 1'b0;
                        r_busy       <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign addr_valid = r_addr_valid;
    assign addr_data  = r_addr_data;
    assign busy       = r_busy;
    assign done       = r_done;
    assign timeout    = r_timeout;
    assign abort      = r_abort;

endmodule
`default_nettype wire

// File: tb/tb_addr_ser.sv
`default_nettype none
// ============================================================================
// Module      : tb_addr_ser
// Description : Directed self-checking bench for addr_ser. A queue-based
//               reference predicts all outputs each cycle; literal checks
//               pin the observed serial streams and pulse counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_addr_ser;

    localparam int AW = 16;
    localparam int DW = 4;
    localparam int TO = 15;
    localparam int MW = AW - DW;

    logic          clk   = 1'b0;
    logic          rstn  = 1'b1;
    logic          start = 1'b0;
    logic          grant = 1'b0;
    logic          ack   = 1'b0;
    logic [AW-1:0] addr_in = '0;
    logic          addr_valid, addr_data, busy, done, timeout, abort;

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_en  = 1'b0;

    addr_ser #(
        .ADDR_WIDTH       (AW),
        .DEVICE_ADDR_WIDTH(DW),
        .ACK_TIMEOUT      (TO)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .addr_in   (addr_in),
        .grant     (grant),
        .ack       (ack),
        .addr_valid(addr_valid),
        .addr_data (addr_data),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .abort     (abort)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference: streams of bits queued per field -----------
    bit          m_active, m_fin;
    int          m_stage;      // 1 device field, 2 awaiting ack, 3 memory field
    int          m_waited;
    bit          m_q[$];
    logic [AW-1:0] m_addr;
    bit e_valid, e_data, e_busy, e_done, e_to, e_abort;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_active = 0; m_fin = 0; m_stage = 0; m_waited = 0; m_q.delete();
            e_valid = 0; e_data = 0; e_busy = 0; e_done = 0; e_to = 0; e_abort = 0;
        end else begin
            e_done = 0; e_to = 0; e_abort = 0;
            if (m_fin) begin
                m_fin = 0;
            end else if (!m_active) begin
                if (start && grant) begin
                    m_addr = addr_in;
                    m_active = 1; m_stage = 1;
                    m_q.delete();
                    for (int i = 0; i < DW; i++) m_q.push_back(m_addr[i]);
                    e_busy = 1; e_valid = 1; e_data = m_q.pop_front();
                end
            end else if (!grant) begin
                m_active = 0; m_q.delete();
                e_valid = 0; e_data = 0; e_busy = 0; e_abort = 1;
            end else if (m_q.size() != 0) begin
                e_valid = 1; e_data = m_q.pop_front();
            end else if (m_stage == 1) begin
                e_valid = 0; e_data = 0; m_stage = 2; m_waited = 0;
            end else if (m_stage == 2) begin
                m_waited++;
                if (ack) begin
                    m_stage = 3;
                    for (int j = DW; j < AW; j++) m_q.push_back(m_addr[j]);
                    e_valid = 1; e_data = m_q.pop_front();
                end else if (m_waited == TO) begin
                    m_active = 0; e_busy = 0; e_to = 1;
                end
            end else begin
                e_valid = 0; e_data = 0; e_busy = 0; e_done = 1;
                m_active = 0; m_fin = 1;
            end
        end
    end

    // Per-cycle comparison of every output against the reference.
    always @(negedge clk) begin
        if (cmp_en)
            chk("outputs", {addr_valid, addr_data, busy, done, timeout, abort},
                {e_valid, e_data, e_busy, e_done, e_to, e_abort});
    end

    // ---------------- observation of what appeared on the bus ---------------
    bit seen[$];
    int n_done, n_to, n_abort, n_busy;

    always @(negedge clk) begin
        if (rstn) begin
            if (addr_valid) seen.push_back(addr_data);
            n_done  += int'(done);
            n_to    += int'(timeout);
            n_abort += int'(abort);
            n_busy  += int'(busy);
        end
    end

    function automatic logic [63:0] seen_word();
        logic [63:0] w = '0;
        for (int i = 0; i < seen.size() && i < 64; i++) w[i] = seen[i];
        return w;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic clear_obs();
        seen.delete(); n_done = 0; n_to = 0; n_abort = 0; n_busy = 0;
    endtask

    task automatic send_start(input logic [AW-1:0] a);
        start = 1'b1; addr_in = a;
        cyc(1);
        start = 1'b0;
        chk("first_bit_valid", addr_valid, 1'b1);
    endtask

    // Full transfer; ack is sampled 'gap' cycles after the last device bit.
    task automatic full_xfer(input logic [AW-1:0] a, input int gap);
        send_start(a);
        cyc(3 + gap);
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        cyc(MW);
        chk("done_pulse", done, 1'b1);
    endtask

    initial begin
        #2 rstn = 1'b0;
        #1 cmp_en = 1'b1;
        cyc(2);
        chk("reset_outputs", {addr_valid, addr_data, busy, done, timeout, abort}, 6'b0);
        rstn = 1'b1; grant = 1'b1;
        cyc(1);

        // Basic transfer 0x00A2 with ack two cycles after the device field.
        clear_obs();
        full_xfer(16'h00A2, 2);
        chk("t1_bit_count", seen.size(), 16);
        chk("t1_stream", seen_word(), 64'h00A2);
        chk("t1_busy_cycles", n_busy, 18);
        cyc(1);
        chk("t1_done_count", n_done, 1);

        // No ack: timeout exactly 15 cycles after entering the wait.
        clear_obs();
        send_start(16'h1234);
        cyc(18);
        chk("t2_no_early_timeout", timeout, 1'b0);
        cyc(1);
        chk("t2_timeout_pulse", {timeout, addr_valid}, 2'b10);
        cyc(1);
        chk("t2_idle_after_timeout", {busy, timeout}, 2'b00);
        chk("t2_dev_bits_only", seen_word(), 64'h4);
        chk("t2_timeout_count", n_to, 1);

        // Grant dropped during the 6th memory bit.
        clear_obs();
        send_start(16'hBEEF);
        cyc(4);
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        cyc(5);
        grant = 1'b0;
        cyc(1);
        chk("t3_abort_state", {abort, addr_valid, addr_data, busy}, 4'b1000);
        grant = 1'b1;
        cyc(3);
        chk("t3_partial_stream", {seen.size(), seen_word()}, {32'd10, 64'h2EF});
        chk("t3_pulses", {n_abort, n_done}, {32'd1, 32'd0});
        clear_obs();
        full_xfer(16'h0F0F, 3);
        chk("t3_recovery_stream", seen_word(), 64'h0F0F);
        cyc(1);

        // start without grant is dropped; start held while busy is ignored.
        clear_obs();
        grant = 1'b0; start = 1'b1; addr_in = 16'hFFFF;
        cyc(1);
        start = 1'b0;
        cyc(3);
        chk("t4_ignored_start", {seen.size(), 31'd0, busy}, 64'd0);
        grant = 1'b1;
        cyc(1);
        start = 1'b1; addr_in = 16'h6C35;
        cyc(1);
        addr_in = 16'hFFFF;
        cyc(4);
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        cyc(10);
        start = 1'b0;
        cyc(2);
        chk("t4_done", done, 1'b1);
        cyc(3);
        chk("t4_single_done", n_done, 1);
        chk("t4_stream", {seen.size(), seen_word()}, {32'd16, 64'h6C35});

        // Asynchronous reset in the middle of the device field.
        clear_obs();
        send_start(16'h5A5A);
        cyc(1);
        #2 rstn = 1'b0;
        #1 chk("t5_async_reset", {addr_valid, addr_data, busy, done, timeout, abort}, 6'b0);
        cyc(2);
        rstn = 1'b1;
        cyc(1);
        clear_obs();
        full_xfer(16'hFFFF, 3);
        chk("t5_all_ones", {seen.size(), seen_word()}, {32'd16, 64'hFFFF});
        cyc(1);

        // Back-to-back transfers; second ack lands on the last allowed cycle.
        clear_obs();
        full_xfer(16'h3C71, 1);
        cyc(1);
        full_xfer(16'h8E05, TO);
        cyc(2);
        chk("t6_stream", {seen.size(), seen_word()}, {32'd32, 64'h8E05_3C71});
        chk("t6_pulses", {n_done, n_to, n_abort}, {32'd2, 32'd0, 32'd0});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
